// File: rtl/kernel_launcher_if.sv
// Host register bus between a controlling master and the kernel launcher.
// The kernel configuration record handed to the block dispatcher is declared here
// so both the launcher and anything driving it share one definition.

typedef struct packed {
    logic [31:0] num_blocks;
    logic [31:0] threads_per_block;
} kernel_config_t;

interface kernel_launcher_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic              host_we;
    logic              host_re;
    logic [ADDR_W-1:0] host_addr;
    logic [31:0]       host_wdata;
    logic [31:0]       host_rdata;
    logic              host_rvalid;

    modport master (
        output host_we,
        output host_re,
        output host_addr,
        output host_wdata,
        input  host_rdata,
        input  host_rvalid
    );

    modport slave (
        input  host_we,
        input  host_re,
        input  host_addr,
        input  host_wdata,
        output host_rdata,
        output host_rvalid
    );
endinterface

// File: rtl/kernel_launcher.sv
// Kernel launcher: host-visible configuration registers and the launch sequencer
// sitting in front of the block dispatcher. A launch clears the dispatcher for one
// cycle, then holds start until finished (or the watchdog expires), records the run
// length and pulses irq on completion.

module kernel_launcher #(
    parameter int unsigned ADDR_W         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    kernel_launcher_if.slave  host,
    output kernel_config_t    kernel_config,
    output logic              start,
    output logic              disp_reset,
    input  logic              finished,
    output logic              busy,
    output logic              irq
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] AddrNumBlocks = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] AddrThreads   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrCtrl      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] AddrStatus    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] AddrCycles    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] AddrLaunches  = ADDR_W'(5);

    localparam bit          TimeoutEn    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_CYCLES);

    state_e         state_q, state_d;
    logic [31:0]    num_blocks_q, num_blocks_d;
    logic [31:0]    threads_q, threads_d;
    logic [31:0]    cycles_q, cycles_d;
    logic [31:0]    launches_q, launches_d;
    logic [31:0]    run_cnt_q, run_cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    kernel_config_t cfg_q, cfg_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic           cfg_err_q, cfg_err_d;
    logic           clr_q, clr_d;
    logic           start_q, start_d;
    logic           busy_q, busy_d;
    logic           irq_q, irq_d;
    logic           rvalid_q, rvalid_d;

    logic           wr_nb, wr_tpb, launch_req, clear_req, in_flight;
    logic [31:0]    run_cnt_inc, status;

    // Decode host strobes and derive the saturating run count and status word.
    always_comb begin
        wr_nb       = host.host_we && (host.host_addr == AddrNumBlocks);
        wr_tpb      = host.host_we && (host.host_addr == AddrThreads);
        // launch takes priority when both CTRL bits are set
        launch_req  = host.host_we && (host.host_addr == AddrCtrl) && host.host_wdata[0];
        clear_req   = host.host_we && (host.host_addr == AddrCtrl) && host.host_wdata[1]
                      && !host.host_wdata[0];
        in_flight   = (state_q == StClear) || (state_q == StRun);
        run_cnt_inc = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 32'd1;
        status      = {28'd0, cfg_err_q, timeout_q, done_q, busy_q};
    end

    // Next-state logic for the sequencer, register file and read port.
    always_comb begin
        state_d      = state_q;
        num_blocks_d = num_blocks_q;
        threads_d    = threads_q;
        cycles_d     = cycles_q;
        launches_d   = launches_q;
        run_cnt_d    = run_cnt_q;
        cfg_d        = cfg_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        cfg_err_d    = cfg_err_q;
        irq_d        = 1'b0;
        rdata_d      = rdata_q;
        rvalid_d     = host.host_re;

        // Configuration writes only land while no kernel is in flight.
        if (in_flight) begin
            if (wr_nb || wr_tpb || launch_req) begin
                cfg_err_d = 1'b1;
            end
        end else begin
            if (wr_nb) begin
                num_blocks_d = host.host_wdata;
            end
            if (wr_tpb) begin
                threads_d = host.host_wdata;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (launch_req) begin
                    launches_d = launches_q + 32'd1;
                    timeout_d  = 1'b0;
                    cfg_err_d  = 1'b0;
                    if (num_blocks_q == 32'd0) begin
                        // Empty grid: complete immediately without touching the dispatcher.
                        state_d  = StDone;
                        cycles_d = 32'd0;
                        done_d   = 1'b1;
                        irq_d    = 1'b1;
                    end else begin
                        state_d                 = StClear;
                        cfg_d.num_blocks        = num_blocks_q;
                        cfg_d.threads_per_block = threads_q;
                        done_d                  = 1'b0;
                        run_cnt_d               = 32'd0;
                    end
                end else if (clear_req && (state_q == StDone)) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end
            StClear: begin
                state_d = StRun;
            end
            StRun: begin
                run_cnt_d = run_cnt_inc;
                if (finished) begin
                    state_d  = StDone;
                    cycles_d = run_cnt_inc;
                    done_d   = 1'b1;
                    irq_d    = 1'b1;
                end else if (TimeoutEn && (run_cnt_inc == TimeoutLimit)) begin
                    state_d   = StDone;
                    cycles_d  = run_cnt_inc;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    irq_d     = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        clr_d   = (state_d == StClear);
        start_d = (state_d == StRun);
        busy_d  = clr_d || start_d;

        // Read mux samples current register values, so a same-cycle write reads old data.
        if (host.host_re) begin
            case (host.host_addr)
                AddrNumBlocks: rdata_d = num_blocks_q;
                AddrThreads:   rdata_d = threads_q;
                AddrStatus:    rdata_d = status;
                AddrCycles:    rdata_d = cycles_q;
                AddrLaunches:  rdata_d = launches_q;
                default:       rdata_d = 32'd0;
            endcase
        end
    end

    // State and registered outputs; reset holds the dispatcher cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            num_blocks_q <= 32'd0;
            threads_q    <= 32'd0;
            cycles_q     <= 32'd0;
            launches_q   <= 32'd0;
            run_cnt_q    <= 32'd0;
            cfg_q        <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            clr_q        <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            irq_q        <= 1'b0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_blocks_q <= num_blocks_d;
            threads_q    <= threads_d;
            cycles_q     <= cycles_d;
            launches_q   <= launches_d;
            run_cnt_q    <= run_cnt_d;
            cfg_q        <= cfg_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            cfg_err_q    <= cfg_err_d;
            clr_q        <= clr_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // Output drive; disp_reset is low during system reset and the single CLEAR cycle.
    always_comb begin
        kernel_config    = cfg_q;
        start            = start_q;
        busy             = busy_q;
        irq              = irq_q;
        disp_reset       = reset & ~clr_q;
        host.host_rdata  = rdata_q;
        host.host_rvalid = rvalid_q;
    end

endmodule
